// File: rtl/msg_comm_pkg.sv
// Shared definitions for the message link transmitter and receiver:
// FSM encodings, CRC-8 constants and the parallel CRC-8 update.
package msg_comm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_TX   = 3'd2,
    ST_CRC  = 3'd3,
    ST_GAP  = 3'd4
  } msg_state_e;

  localparam logic [7:0] CRC8_INIT = 8'hFF;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One byte of x^8+x^2+x+1, MSB first, unrolled into XOR equations
  function automatic logic [7:0] nextCRC8D8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] x;
    logic [7:0] c;
    x    = data ^ crc;
    c[0] = x[7] ^ x[6] ^ x[0];
    c[1] = x[6] ^ x[1] ^ x[0];
    c[2] = x[6] ^ x[2] ^ x[1] ^ x[0];
    c[3] = x[7] ^ x[3] ^ x[2] ^ x[1];
    c[4] = x[4] ^ x[3] ^ x[2];
    c[5] = x[5] ^ x[4] ^ x[3];
    c[6] = x[6] ^ x[5] ^ x[4];
    c[7] = x[7] ^ x[6] ^ x[5];
    return c;
  endfunction

endpackage

// File: rtl/message_comm_tx_if.sv
// Byte-stream load port of the message transmitter.
interface message_comm_tx_if;
  logic       msg_tx_data_vld_i;
  logic [7:0] msg_tx_data_i;
  logic       msg_tx_data_last_i;
  logic       msg_tx_ready_o;
  logic       msg_tx_ovf_o;
  logic       msg_tx_busy_o;

  modport master (
    output msg_tx_data_vld_i, msg_tx_data_i, msg_tx_data_last_i,
    input  msg_tx_ready_o, msg_tx_ovf_o, msg_tx_busy_o
  );

  modport slave (
    input  msg_tx_data_vld_i, msg_tx_data_i, msg_tx_data_last_i,
    output msg_tx_ready_o, msg_tx_ovf_o, msg_tx_busy_o
  );
endinterface

// File: rtl/msg_comm_tx_ram.sv
// Frame buffer: simple dual-port RAM, synchronous write, registered read.
module msg_comm_tx_ram #(
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/message_comm_tx.sv
// Message link transmitter: buffers one frame, appends CRC-8 and shifts it
// out MSB-first under FSX, with data launched on MSG_CLK falling edges.
//
// state   | meaning
// IDLE    | loading payload bytes, ready high
// WAIT    | frame committed, prefetching byte 0, waiting for a falling edge
// TX      | shifting payload bits
// CRC     | shifting the 8 CRC bits
// GAP     | FSX low, counting inter-frame MSG_CLK periods
module message_comm_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned DEPTH_AW = 11,
  parameter int unsigned GAP_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  message_comm_tx_if.slave tx_if,
  output logic             MSG_CLK,
  output logic             MSG_TX_FSX,
  output logic             MSG_TX
);
  import msg_comm_pkg::*;

  localparam logic [7:0]          DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [15:0]         GAP_LOAD   = 16'(GAP_BITS - 1);
  localparam logic [DEPTH_AW:0]   WR_FULL    = {1'b1, {DEPTH_AW{1'b0}}};
  localparam logic [DEPTH_AW:0]   CNT_ONE    = (DEPTH_AW+1)'(1);

  logic [7:0] div_cnt_q;
  logic       msg_clk_q;
  logic       fall_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= DIV_RELOAD;
      msg_clk_q <= 1'b0;
    end else if (div_cnt_q == 8'd0) begin
      div_cnt_q <= DIV_RELOAD;
      msg_clk_q <= ~msg_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q - 8'd1;
    end
  end

  // High on the clk edge that takes MSG_CLK from 1 to 0
  assign fall_en = (div_cnt_q == 8'd0) && msg_clk_q;

  msg_state_e          state_q, state_d;
  logic [DEPTH_AW:0]   wr_cnt_q, wr_cnt_d;
  logic [DEPTH_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]          crc_q, crc_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [15:0]         gap_cnt_q, gap_cnt_d;
  logic                fsx_q, fsx_d;
  logic                tx_q, tx_d;
  logic                pf_vld_q, pf_vld_d;
  logic                ovf_q, ovf_d;
  logic                ram_we;
  logic [7:0]          ram_rd_data;
  logic                ready;
  logic                accept;

  msg_comm_tx_ram #(.AW(DEPTH_AW)) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .wr_addr_i (wr_cnt_q[DEPTH_AW-1:0]),
    .wr_data_i (tx_if.msg_tx_data_i),
    .rd_addr_i (rd_ptr_q[DEPTH_AW-1:0]),
    .rd_data_o (ram_rd_data)
  );

  assign ready  = (state_q == ST_IDLE);
  assign accept = tx_if.msg_tx_data_vld_i && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      crc_q     <= CRC8_INIT;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      fsx_q     <= 1'b0;
      tx_q      <= 1'b0;
      pf_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      crc_q     <= crc_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      fsx_q     <= fsx_d;
      tx_q      <= tx_d;
      pf_vld_q  <= pf_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    crc_d     = crc_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    fsx_d     = fsx_q;
    tx_d      = tx_q;
    pf_vld_d  = pf_vld_q;
    ovf_d     = 1'b0;
    ram_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (wr_cnt_q == WR_FULL) begin
            ovf_d = 1'b1;
          end else begin
            ram_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + CNT_ONE;
            crc_d    = nextCRC8D8(tx_if.msg_tx_data_i, crc_q);
          end
          if (tx_if.msg_tx_data_last_i) begin
            state_d  = ST_WAIT;
            pf_vld_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        // Byte 0 may have been written on the commit edge, so give the
        // registered read one cycle before trusting it.
        pf_vld_d = 1'b1;
        if (fall_en && pf_vld_q) begin
          fsx_d     = 1'b1;
          tx_d      = ram_rd_data[7];
          shift_d   = {ram_rd_data[6:0], 1'b0};
          bit_cnt_d = 3'd7;
          rd_ptr_d  = rd_ptr_q + CNT_ONE;
          state_d   = ST_TX;
        end
      end
      ST_TX: begin
        if (fall_en) begin
          if (bit_cnt_q != 3'd0) begin
            tx_d      = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else if (rd_ptr_q == wr_cnt_q) begin
            tx_d      = crc_q[7];
            shift_d   = {crc_q[6:0], 1'b0};
            bit_cnt_d = 3'd7;
            state_d   = ST_CRC;
          end else begin
            tx_d      = ram_rd_data[7];
            shift_d   = {ram_rd_data[6:0], 1'b0};
            bit_cnt_d = 3'd7;
            rd_ptr_d  = rd_ptr_q + CNT_ONE;
          end
        end
      end
      ST_CRC: begin
        if (fall_en) begin
          if (bit_cnt_q != 3'd0) begin
            tx_d      = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else begin
            fsx_d     = 1'b0;
            tx_d      = 1'b0;
            gap_cnt_d = GAP_LOAD;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (fall_en) begin
          if (gap_cnt_q == 16'd0) begin
            wr_cnt_d = '0;
            rd_ptr_d = '0;
            crc_d    = CRC8_INIT;
            state_d  = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_if.msg_tx_ready_o = ready;
  assign tx_if.msg_tx_busy_o  = ~ready;
  assign tx_if.msg_tx_ovf_o   = ovf_q;
  assign MSG_CLK    = msg_clk_q;
  assign MSG_TX_FSX = fsx_q;
  assign MSG_TX     = tx_q;

endmodule

// File: tb/tb_message_comm_tx.sv
// Directed bench for message_comm_tx: a CLK_DIV=2 instance with an 8-byte
// buffer and a CLK_DIV=1 instance, decoded by a MSG_CLK-rising-edge monitor.
module tb_message_comm_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  message_comm_tx_if if0();
  message_comm_tx_if if1();

  logic [1:0] mclk, fsx, txd;
  logic [1:0] rdy, busy, ovf;

  message_comm_tx #(.CLK_DIV(2), .DEPTH_AW(3), .GAP_BITS(16)) dut0 (
    .clk(clk), .rst(rst), .tx_if(if0),
    .MSG_CLK(mclk[0]), .MSG_TX_FSX(fsx[0]), .MSG_TX(txd[0])
  );

  message_comm_tx #(.CLK_DIV(1), .DEPTH_AW(3), .GAP_BITS(4)) dut1 (
    .clk(clk), .rst(rst), .tx_if(if1),
    .MSG_CLK(mclk[1]), .MSG_TX_FSX(fsx[1]), .MSG_TX(txd[1])
  );

  assign rdy  = {if1.msg_tx_ready_o, if0.msg_tx_ready_o};
  assign busy = {if1.msg_tx_busy_o,  if0.msg_tx_busy_o};
  assign ovf  = {if1.msg_tx_ovf_o,   if0.msg_tx_ovf_o};

  int errs = 0;
  int checks = 0;
  bit align_en = 1'b0;

  logic [1:0] mclk_p = '0, fsx_p = '0, tx_p = '0;
  int         cap_bits [2];
  logic [7:0] cap      [2][16];
  int         fsx_cyc  [2];
  int         low_run  [2];
  int         last_low [2];
  int         ovf_cnt  [2];
  logic [7:0] exp_b    [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [7:0] d, input logic [7:0] c);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Serial decoder and edge-alignment monitor, sampled mid-cycle
  initial begin
    for (int i = 0; i < 2; i++) begin
      cap_bits[i] = 0; fsx_cyc[i] = 0; low_run[i] = 0; last_low[i] = 0; ovf_cnt[i] = 0;
    end
  end

  always begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (align_en && (fsx[i] !== fsx_p[i] || txd[i] !== tx_p[i])) begin
        checks++;
        assert (mclk_p[i] === 1'b1 && mclk[i] === 1'b0) else begin
          errs++;
          $error("FAIL align%0d: data/fsx moved with MSG_CLK %b->%b, required 1->0", i, mclk_p[i], mclk[i]);
        end
      end
      if (fsx[i] === 1'b1) begin
        fsx_cyc[i]++;
        if (low_run[i] > 0) last_low[i] = low_run[i];
        low_run[i] = 0;
        if (mclk[i] === 1'b1 && mclk_p[i] === 1'b0) begin
          if (cap_bits[i] < 128)
            cap[i][4'(cap_bits[i] >> 3)] = {cap[i][4'(cap_bits[i] >> 3)][6:0], txd[i]};
          cap_bits[i]++;
        end
      end else begin
        low_run[i]++;
      end
      if (ovf[i] === 1'b1) ovf_cnt[i]++;
    end
    mclk_p = mclk;
    fsx_p  = fsx;
    tx_p   = txd;
  end

  task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
    if (i == 0) begin
      if0.msg_tx_data_vld_i = v; if0.msg_tx_data_i = d; if0.msg_tx_data_last_i = l;
    end else begin
      if1.msg_tx_data_vld_i = v; if1.msg_tx_data_i = d; if1.msg_tx_data_last_i = l;
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic l);
    @(negedge clk);
    drive(i, 1'b1, d, l);
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int i, input bit use_rdy);
    return use_rdy ? rdy[i] : fsx[i];
  endfunction

  task automatic wait_sig(input string tag, input int i, input bit use_rdy,
                          input logic lvl, input int budget, output int n);
    n = 0;
    while (sel(i, use_rdy) !== lvl && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, sel(i, use_rdy), lvl);
  endtask

  task automatic clear_cap(input int i);
    cap_bits[i] = 0;
    fsx_cyc[i]  = 0;
  endtask

  task automatic check_frame(input string tag, input int i, input int nb);
    logic [7:0] c;
    c = 8'hFF;
    chk({tag, "_bits"}, cap_bits[i], 8 * (nb + 1));
    for (int k = 0; k < nb; k++) begin
      chk({tag, "_byte"}, cap[i][k], exp_b[k]);
      c = crc_model(exp_b[k], c);
    end
    chk({tag, "_crc"}, cap[i][nb], c);
  endtask

  initial begin
    int n;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mclk",  mclk[0], 0);
    chk("rst_fsx",   fsx[0],  0);
    chk("rst_tx",    txd[0],  0);
    chk("rst_ready", rdy[0],  1);
    chk("rst_busy",  busy[0], 0);
    chk("rst_ovf",   ovf[0],  0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    align_en = 1'b1;

    // 3-byte frame: 01 02 03, CRC 0x63
    clear_cap(0);
    send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b0); send(0, 8'h03, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    chk("a_ready_drop", rdy[0], 0);
    chk("a_busy", busy[0], 1);
    wait_sig("a_fsx_rise", 0, 1'b0, 1'b1, 20, n);
    chk("a_latency_1to5", (n >= 1 && n <= 5), 1);
    wait_sig("a_fsx_fall", 0, 1'b0, 1'b0, 400, n);
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
    check_frame("a", 0, 3);
    chk("a_crc_const", cap[0][3], 8'h63);
    chk("a_fsx_cycles", fsx_cyc[0], 128);
    wait_sig("a_ready_back", 0, 1'b1, 1'b1, 200, n);
    chk("a_gap_cycles", n, 64);

    // single byte 0x00, CRC 0xF3
    clear_cap(0);
    send(0, 8'h00, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_sig("b_fsx_rise", 0, 1'b0, 1'b1, 20, n);
    wait_sig("b_fsx_fall", 0, 1'b0, 1'b0, 200, n);
    exp_b[0] = 8'h00;
    check_frame("b", 0, 1);
    chk("b_crc_const", cap[0][1], 8'hF3);
    chk("b_fsx_cycles", fsx_cyc[0], 64);
    wait_sig("b_ready_back", 0, 1'b1, 1'b1, 200, n);

    // back-to-back frames with vld held high across tx and gap
    clear_cap(0);
    send(0, 8'hA5, 1'b0); send(0, 8'h3C, 1'b1);
    drive(0, 1'b1, 8'h55, 1'b0);
    wait_sig("c_fsx_rise", 0, 1'b0, 1'b1, 20, n);
    wait_sig("c_fsx_fall", 0, 1'b0, 1'b0, 400, n);
    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C;
    check_frame("c", 0, 2);
    clear_cap(0);
    wait_sig("c_ready_back", 0, 1'b1, 1'b1, 200, n);
    chk("c_gap_cycles", n, 64);
    @(posedge clk);
    #1;
    send(0, 8'h66, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_sig("d_fsx_rise", 0, 1'b0, 1'b1, 20, n);
    @(negedge clk);
    #1;
    chk("cd_fsx_low_ge_gap", (last_low[0] >= 64), 1);
    wait_sig("d_fsx_fall", 0, 1'b0, 1'b0, 400, n);
    exp_b[0] = 8'h55; exp_b[1] = 8'h66;
    check_frame("d", 0, 2);
    chk("d_no_ovf", ovf_cnt[0], 0);
    wait_sig("d_ready_back", 0, 1'b1, 1'b1, 200, n);

    // 9 bytes into an 8-byte buffer
    clear_cap(0);
    for (int k = 0; k < 8; k++) begin
      send(0, 8'h10 + 8'(k), 1'b0);
      chk("ovf_early", ovf[0], 0);
    end
    send(0, 8'h18, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    chk("ovf_pulse", ovf[0], 1);
    @(posedge clk);
    #1;
    chk("ovf_one_cycle", ovf[0], 0);
    wait_sig("ovf_fsx_rise", 0, 1'b0, 1'b1, 20, n);
    wait_sig("ovf_fsx_fall", 0, 1'b0, 1'b0, 1000, n);
    for (int k = 0; k < 8; k++) exp_b[k] = 8'h10 + 8'(k);
    check_frame("ovf", 0, 8);
    chk("ovf_fsx_cycles", fsx_cyc[0], 288);
    chk("ovf_count", ovf_cnt[0], 1);
    wait_sig("ovf_ready_back", 0, 1'b1, 1'b1, 200, n);

    // asynchronous reset during byte 1 of a frame
    clear_cap(0);
    send(0, 8'hC3, 1'b0); send(0, 8'h5A, 1'b0); send(0, 8'h99, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_sig("r_fsx_rise", 0, 1'b0, 1'b1, 20, n);
    n = 0;
    while (cap_bits[0] < 10 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("r_reached_byte1", (cap_bits[0] >= 10), 1);
    align_en = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("r_async_fsx",   fsx[0],  0);
    chk("r_async_tx",    txd[0],  0);
    chk("r_async_mclk",  mclk[0], 0);
    chk("r_async_ready", rdy[0],  1);
    chk("r_async_busy",  busy[0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    align_en = 1'b1;
    chk("r_ready_after", rdy[0], 1);
    clear_cap(0);
    send(0, 8'hA7, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_sig("r2_fsx_rise", 0, 1'b0, 1'b1, 20, n);
    wait_sig("r2_fsx_fall", 0, 1'b0, 1'b0, 200, n);
    exp_b[0] = 8'hA7;
    check_frame("r2", 0, 1);
    wait_sig("r2_ready_back", 0, 1'b1, 1'b1, 200, n);

    // CLK_DIV=1 instance: MSG_CLK = clk/2
    clear_cap(1);
    send(1, 8'h3C, 1'b0); send(1, 8'hF0, 1'b1);
    drive(1, 1'b0, 8'h00, 1'b0);
    chk("k1_ready_drop", rdy[1], 0);
    wait_sig("k1_fsx_rise", 1, 1'b0, 1'b1, 20, n);
    chk("k1_latency_1to3", (n >= 1 && n <= 3), 1);
    wait_sig("k1_fsx_fall", 1, 1'b0, 1'b0, 200, n);
    exp_b[0] = 8'h3C; exp_b[1] = 8'hF0;
    check_frame("k1", 1, 2);
    chk("k1_fsx_cycles", fsx_cyc[1], 48);
    wait_sig("k1_ready_back", 1, 1'b1, 1'b1, 100, n);
    chk("k1_gap_cycles", n, 8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/message_comm_tx.md
# message_comm_tx

Serial message transmitter: the transmit end of the MSG_CLK / FSX / data link whose receiver is `message_comm_rx`. It accepts one frame of bytes on a valid/last byte stream, buffers it, and appends a CRC-8. It then serializes the frame MSB-first with frame sync held high for the whole frame, and drives a forwarded `MSG_CLK` derived from the system clock. It sits between the ethernet/command side and the board-to-board message pins.

## Interface
- `CLK_DIV`, 2: `MSG_CLK` half-period in `clk` cycles; legal range 1..255.
- `DEPTH_AW`, 11: frame buffer address width; maximum payload is 2^DEPTH_AW bytes.
- `GAP_BITS`, 16: minimum count of `MSG_CLK` periods with FSX low between frames.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `msg_tx_data_vld_i`  in  1  payload byte valid; accepted only when `msg_tx_ready_o`=1.
- `msg_tx_data_i`  in  8  payload byte.
- `msg_tx_data_last_i`  in  1  marks the final payload byte; qualified by vld.
- `msg_tx_ready_o`  out  1  block is in load state and accepts bytes.
- `msg_tx_ovf_o`  out  1  one-cycle pulse when an accepted byte is dropped because the buffer is full.
- `msg_tx_busy_o`  out  1  high from frame commit until the end of the gap.
- `MSG_CLK`  out  1  forwarded serial clock; free-running.
- `MSG_TX_FSX`  out  1  frame sync; high for every bit of the frame, CRC byte included.
- `MSG_TX`  out  1  serial data, MSB first.

## Operation
- The `MSG_CLK` generator is a counter that toggles `MSG_CLK` every `CLK_DIV` clk cycles. A one-cycle strobe `fall_en` fires on the clk edge where `MSG_CLK` goes 1→0. `MSG_TX_FSX` and `MSG_TX` change only on `fall_en`, so the receiver samples stable data on the `MSG_CLK` rising edge.
- Load (ST_IDLE):
  - Each accepted byte is written to the buffer at `wr_cnt`, and `wr_cnt` increments.
  - The CRC is updated in the same cycle: CRC-8, poly x^8+x^2+x+1, init 0xFF, MSB-first, no reflection, no final XOR.
  - If `wr_cnt` = 2^DEPTH_AW, the byte is not stored, the CRC is not updated, and `msg_tx_ovf_o` pulses.
  - A `last` beat is handled as a normal byte, then the block commits the frame: `msg_tx_ready_o` goes low and the FSM enters ST_WAIT.
- ST_WAIT: prefetch byte 0 from the buffer. On `fall_en`, raise FSX, drive bit 7 and enter ST_TX.
- ST_TX:
  - Each `fall_en` shifts out the next bit.
  - After bit 0 of byte `wr_cnt-1`, the next `fall_en` loads the CRC into the shifter and the FSM enters ST_CRC.
  - Prefetch of byte k+1 completes before the `fall_en` that needs it.
- ST_CRC: shift out 8 CRC bits. On the `fall_en` after CRC bit 0, drive FSX=0 and MSG_TX=0, then enter ST_GAP.
- ST_GAP: count `GAP_BITS` `fall_en` strobes, clear `wr_cnt` and the CRC (to 0xFF), raise ready, and return to ST_IDLE.
- vld while ready=0 is ignored. No byte is consumed and no overflow is flagged.
- A frame always holds at least 1 byte, because the last beat is itself a byte.

## Timing
- Reset values:
  - `MSG_CLK`=0, `MSG_TX_FSX`=0, `MSG_TX`=0.
  - `msg_tx_ready_o`=1, `msg_tx_busy_o`=0, `msg_tx_ovf_o`=0.
  - FSM in ST_IDLE, `wr_cnt`=0, CRC=0xFF.
- Reset asserted mid-frame: all outputs go immediately to their reset values and the frame is discarded.
- Byte acceptance: zero-latency, the byte is taken in the same cycle as vld&ready. Ready drops the cycle after the last beat.
- FSX rises at the first `fall_en` at least 1 clk after commit, which is at most 2·CLK_DIV+1 clk cycles after the last beat.
- FSX stays high for exactly 8·(N+1) `MSG_CLK` periods (N = payload bytes), which is 16·CLK_DIV·(N+1) clk cycles.
- Ready re-asserts `GAP_BITS` `MSG_CLK` periods after FSX falls.
- Full frame of 2^DEPTH_AW bytes: all bytes are sent and `wr_cnt` is DEPTH_AW+1 bits wide. This matches the receiver's 2048-entry RAM.

## Structure
- Package `msg_comm_pkg`:
  - state encodings ST_IDLE=0, ST_WAIT=1, ST_TX=2, ST_CRC=3, ST_GAP=4 (same numbering as the receiver);
  - constants CRC8_INIT=8'hFF and CRC8_POLY=8'h07;
  - function `nextCRC8D8(data, crc)`, shared with `message_comm_rx`.
- Sub-module `msg_comm_tx_ram`: simple dual-port, 2^DEPTH_AW×8, single clock, synchronous write, registered read.

## Test plan
- Payload 0x01,0x02,0x03 with CLK_DIV=2 → 32 bits under FSX = 0x01 0x02 0x03 0x63 MSB-first. FSX is high for 128 clk cycles. A loopback into `message_comm_rx` reproduces the 3 payload bytes with CRC passing.
- Single byte 0x00 with last → serial 0x00 then CRC 0xF3. FSX is high for 16 `MSG_CLK` periods.
- Back-to-back frames with vld held high → ready is low for the whole tx+gap. FSX low lasts ≥ GAP_BITS periods. The second frame's CRC is computed from 0xFF, not chained from the first frame.
- 2049 bytes offered → exactly one `msg_tx_ovf_o` pulse on byte 2049. 2048 bytes plus CRC are sent.
- `rst` pulsed during ST_TX byte 1 → FSX, MSG_TX and MSG_CLK go to 0 asynchronously. Ready=1 after release. The next 1-byte frame transmits correctly.
- CLK_DIV=1 → `MSG_CLK` = clk/2. Data and FSX transitions align only with `MSG_CLK` falling edges, checked by an assertion over the whole run.
